// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if
//   Request/result bundle between a multiply requester and alu_mul_seq.
//   start   : request a multiply (requester -> sequencer)
//   a, b    : multiplicand / multiplier, 16 bits (requester -> sequencer)
//   busy    : multiply in progress, sequencer owns the ALU (sequencer -> requester)
//   done    : one-cycle completion strobe (sequencer -> requester)
//   product : low 16 bits of a*b, held until the next completion
//   Modports: master = requester side, slave = sequencer side.
interface alu_mul_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Shift-and-add 16-bit multiplier that borrows the shared Hack-style ALU for
//   every addition (acc + mcand) and every doubling (mcand + mcand). Produces
//   the low 16 bits of a*b, valid for unsigned and two's-complement operands.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     bus (slave)     : start/a/b request, busy/done/product result
//     alu_x, alu_y    : ALU operands driven by this block
//     alu_zx..alu_no  : ALU control bits driven by this block
//     alu_out         : ALU result, combinational from the drives above
//     alu_zr, alu_ng  : ALU flags, not used here
//   All outputs come straight from flops; the ALU drive for the next state is
//   computed alongside the state so that alu_out is ready within that state.
module alu_mul_seq (
    input  logic               clk,
    input  logic               rst_n,
    alu_mul_seq_if.slave       bus,
    output logic [15:0]        alu_x,
    output logic [15:0]        alu_y,
    output logic               alu_zx,
    output logic               alu_nx,
    output logic               alu_zy,
    output logic               alu_ny,
    output logic               alu_f,
    output logic               alu_no,
    input  logic [15:0]        alu_out,
    input  logic               alu_zr,
    input  logic               alu_ng
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DBL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic [15:0] acc_q,     acc_d;
    logic [15:0] mcand_q,   mcand_d;
    logic [15:0] mplier_q,  mplier_d;
    logic [15:0] product_q, product_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic [15:0] alu_x_q,   alu_x_d;
    logic [15:0] alu_y_q,   alu_y_d;
    logic        alu_f_q,   alu_f_d;

    // The flags are part of the shared ALU bundle but carry nothing we need.
    logic unused_alu_flags;
    assign unused_alu_flags = alu_zr ^ alu_ng;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    acc_d    = 16'd0;
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    // A zero multiplier needs no steps at all.
                    state_d  = (bus.b != 16'd0) ? S_ADD : S_DONE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ADD: begin
                // ALU is computing acc + mcand this cycle.
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                end
                state_d = S_DBL;
            end
            S_DBL: begin
                // ALU is computing mcand + mcand this cycle.
                mcand_d  = alu_out;
                mplier_d = mplier_q >> 1;
                // Stop as soon as no set bits remain in the multiplier.
                state_d  = (mplier_q[15:1] == 15'd0) ? S_DONE : S_ADD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture the finished accumulator on every edge that lands in DONE.
        if (state_d == S_DONE) begin
            product_d = acc_d;
        end

        busy_d  = (state_d == S_ADD) || (state_d == S_DBL);
        done_d  = (state_d == S_DONE);
        alu_f_d = busy_d;

        // Operand drive for the state being entered, so alu_out is valid in it.
        case (state_d)
            S_ADD: begin
                alu_x_d = acc_d;
                alu_y_d = mcand_d;
            end
            S_DBL: begin
                alu_x_d = mcand_d;
                alu_y_d = mcand_d;
            end
            default: begin
                alu_x_d = acc_d;
                alu_y_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= 16'd0;
            mcand_q   <= 16'd0;
            mplier_q  <= 16'd0;
            product_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_x_q   <= 16'd0;
            alu_y_q   <= 16'd0;
            alu_f_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_x_q   <= alu_x_d;
            alu_y_q   <= alu_y_d;
            alu_f_q   <= alu_f_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

    assign alu_x  = alu_x_q;
    assign alu_y  = alu_y_q;
    assign alu_f  = alu_f_q;
    // Only x+y is ever requested, so the remaining controls never change.
    assign alu_zx = 1'b0;
    assign alu_nx = 1'b0;
    assign alu_zy = 1'b0;
    assign alu_ny = 1'b0;
    assign alu_no = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
//   Bench for alu_mul_seq: a Hack ALU model closes the loop, a timeline
//   reference model predicts busy/done/product per cycle, and directed plus
//   random multiplies pin latency and results.
module tb_alu_mul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_mul_seq_if bus ();

    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_zr, alu_ng;

    int checks = 0;
    int failures = 0;

    alu_mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_zx  (alu_zx),
        .alu_nx  (alu_nx),
        .alu_zy  (alu_zy),
        .alu_ny  (alu_ny),
        .alu_f   (alu_f),
        .alu_no  (alu_no),
        .alu_out (alu_out),
        .alu_zr  (alu_zr),
        .alu_ng  (alu_ng)
    );

    always #5 clk = ~clk;

    // Hack ALU.
    always_comb begin
        logic [15:0] xv, yv, ov;
        xv = alu_zx ? 16'd0 : alu_x;
        xv = alu_nx ? ~xv : xv;
        yv = alu_zy ? 16'd0 : alu_y;
        yv = alu_ny ? ~yv : yv;
        ov = alu_f ? (xv + yv) : (xv & yv);
        ov = alu_no ? ~ov : ov;
        alu_out = ov;
        alu_zr  = (ov == 16'd0);
        alu_ng  = ov[15];
    end

    function automatic int k_of(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Timeline model: an accepted start at cycle c gives busy in c+1..c+2k,
    // done in c+2k+1 with product = a*b mod 2^16.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_product = 16'd0;
    logic [15:0] m_pending = 16'd0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_product = 16'd0;
            m_left    = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy    = 1'b0;
                m_done    = 1'b1;
                m_product = m_pending;
            end
        end else if (bus.start) begin
            m_pending = 16'((32'(bus.a) * 32'(bus.b)) & 32'hFFFF);
            m_left    = 2 * k_of(bus.b);
            if (m_left == 0) begin
                m_done    = 1'b1;
                m_product = m_pending;
            end else begin
                m_busy = 1'b1;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("product", 32'(bus.product), 32'(m_product));
            check("alu_f", 32'(alu_f), 32'(m_busy));
            check("alu_ctl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_no}), 32'd0);
            if (!m_busy) check("alu_y_idle", 32'(alu_y), 32'd0);
        end
    end

    // Caller is at a negedge with the DUT in IDLE or DONE; returns at the
    // negedge of the done cycle with start low.
    task automatic do_mul(input logic [15:0] ia, input logic [15:0] ib,
                          input logic [15:0] ep, input int elat,
                          input bit noise, input string nm);
        int cyc;
        bus.start = 1'b1;
        bus.a = ia;
        bus.b = ib;
        @(negedge clk);
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({nm, "_latency"}, 32'(cyc), 32'(elat));
        check({nm, "_product"}, 32'(bus.product), 32'(ep));
    endtask

    initial begin
        int cyc;
        logic [15:0] ra, rb;
        bus.start = 1'b0;
        bus.a = 16'd0;
        bus.b = 16'd0;

        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_alu_x", 32'(alu_x), 32'd0);
        check("rst_alu_f", 32'(alu_f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_mul(16'd3, 16'd5, 16'd15, 7, 1'b0, "mul3x5");
        repeat (10) @(negedge clk);
        check("mul3x5_hold", 32'(bus.product), 32'd15);

        do_mul(16'h1234, 16'd0, 16'd0, 1, 1'b0, "mul_b0");
        @(negedge clk);
        do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 33, 1'b1, "mul_neg1");
        @(negedge clk);
        do_mul(16'd300, 16'd300, 16'h5F90, 19, 1'b0, "mul_wrap");
        @(negedge clk);

        // 7x9 with an ignored start in ADD, then back-to-back 4x4.
        bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd9;
        @(negedge clk);
        check("ign_in_add", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd2;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 2;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("mul7x9_latency", 32'(cyc), 32'd9);
        check("mul7x9_product", 32'(bus.product), 32'd63);
        bus.start = 1'b1; bus.a = 16'd4; bus.b = 16'd4;
        @(negedge clk);
        check("b2b_add_busy", 32'(bus.busy), 32'd1);
        check("b2b_add_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("mul4x4_latency", 32'(cyc), 32'd7);
        check("mul4x4_product", 32'(bus.product), 32'd16);
        @(negedge clk);

        // Asynchronous reset in cycle 4 of 0xFF x 0xFF.
        bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h00FF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_product", 32'(bus.product), 32'd0);
        check("arst_alu_f", 32'(alu_f), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_product", 32'(bus.product), 32'd0);
        do_mul(16'd6, 16'd7, 16'd42, 7, 1'b0, "mul6x7");

        // Random operands with varied multiplier widths, gaps and back-to-back.
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_mul(ra, rb, 16'((32'(ra) * 32'(rb)) & 32'hFFFF),
                   2 * k_of(rb) + 1, 1'b1, "rand");
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiplier sequencer that reuses the shared Hack-style ALU (x/y operands, zx/nx/zy/ny/f/no controls, out/zr/ng results) instead of a dedicated multiplier. It implements shift-and-add multiplication: the ALU does every addition and every left shift (x+x), and the block keeps the accumulator, the multiplicand and the multiplier. It sits beside the ALU in the datapath and owns the ALU's operand and control inputs while a multiply is in progress. Results are the low 16 bits of the product, which are correct for both unsigned and two's-complement operands.

## Interface
- No parameters; width fixed at 16.
- `clk` in 1: single clock, all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only in IDLE or DONE.
- `a` in 16: multiplicand, captured on an accepted `start`.
- `b` in 16: multiplier, captured on an accepted `start`.
- `busy` out 1: high in ADD and DBL.
- `done` out 1: high for exactly one cycle, in DONE.
- `product` out 16: low 16 bits of a*b; holds until the next completion.
- `alu_x`, `alu_y` out 16 each: ALU operands.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no` out 1 each: ALU controls.
- `alu_out` in 16: ALU result, combinational from the drives above in the same cycle.
- `alu_zr`, `alu_ng` in 1: present on the port but unused by this block.

## Operation
- Internal registers:
  - `acc` (16): accumulator.
  - `mcand` (16): multiplicand, doubled each step.
  - `mplier` (16): multiplier, shifted right each step.
  - FSM state.
- States: IDLE, ADD, DBL, DONE.
- IDLE:
  - `start`=1: `acc`<=0, `mcand`<=`a`, `mplier`<=`b`.
  - Next state is ADD if `b`!=0, otherwise DONE.
- ADD:
  - ALU drive: `alu_x`=`acc`, `alu_y`=`mcand`, controls zx=0 nx=0 zy=0 ny=0 f=1 no=0 (x+y).
  - If `mplier[0]`=1: `acc`<=`alu_out`. Otherwise `acc` is unchanged and the ALU result is ignored.
  - Next state: DBL.
- DBL:
  - ALU drive: `alu_x`=`mcand`, `alu_y`=`mcand`, same add controls.
  - `mcand`<=`alu_out`; `mplier`<=`mplier`>>1 (zero fill).
  - Next state: DONE if the shifted `mplier` is 0, otherwise ADD. This early exit means high zero bits of `b` cost nothing.
- DONE:
  - `product` is loaded with `acc` on the edge that enters DONE, so it is valid while `done`=1.
  - `start`=1 behaves exactly as in IDLE (back-to-back operation).
  - `start`=0 returns to IDLE.
- IDLE and DONE ALU drive: `alu_x`=`acc`, `alu_y`=0, all controls 0. The ALU is free for other owners; the top-level mux selects this block only while `busy`.
- `start` in ADD or DBL is ignored; the operands `a` and `b` are not re-sampled.
- All additions wrap modulo 2^16. Carries out of bit 15 are discarded and no overflow is reported.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE, `busy`=0, `done`=0.
  - `product`=0, `acc`=0, `mcand`=0, `mplier`=0.
  - ALU drive to the IDLE values.
- Reset mid-operation abandons the multiply. No `done` is produced, and `product` reads 0.
- Let k be the index of the highest set bit of `b` plus 1 (1..16), with k=0 for `b`=0.
- Cycle 0 is the cycle in which `start` is sampled high in IDLE or DONE.
  - Cycles 1..2k alternate ADD, DBL with `busy`=1.
  - `done`=1 in cycle 2k+1.
- Latency: minimum 1 cycle (`b`=0), maximum 33 cycles (`b[15]`=1).
- `alu_out` must settle within one cycle; the block has no ALU pipeline stages.
- Back-to-back: `start` held high through DONE begins the next ADD in the following cycle. There are no idle bubbles between operations.

## Test plan
- Basic multiply: `a`=3, `b`=5, one-cycle `start`.
  - Expect `busy` high for cycles 1–6.
  - Expect `done` for one cycle in cycle 7 with `product`=15.
  - Expect `product` still 15 ten cycles later.
- Zero multiplier: `a`=0x1234, `b`=0.
  - Expect `done` in cycle 1, `product`=0, and `busy` never high.
- Signed, worst-case latency: `a`=0xFFFF, `b`=0xFFFF.
  - Expect `product`=0x0001 with `done` in cycle 33.
  - Expect `alu_zx..alu_no` = 0,0,0,0,1,0 in every busy cycle.
- Wrap-around: `a`=300, `b`=300 → `product`=0x5F90 (90000 mod 65536).
- Ignored start and back-to-back: start 7×9.
  - Pulse `start` with `a`=2, `b`=2 during ADD: it must be ignored, and the first result is `product`=63.
  - Hold `start` with `a`=4, `b`=4 during the DONE cycle: the next cycle must be ADD, and the second `done` reports 16.
- Reset mid-operation: assert `rst_n`=0 asynchronously in cycle 4 of 0x00FF×0x00FF.
  - `busy`, `done` and `product` must go to 0 immediately, without waiting for a clock edge.
  - After release, a new 6×7 must give 42.
